face_turn_driver: RTL and testbench



---
 rtl/face_turn_driver.sv | 150 +++++++++++++++
 tb/tb_face_turn_driver.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/face_turn_driver.sv
// Face quarter-turn executor: decodes a move code, enables one stepper
// driver, emits a fixed step train, settles, then pulses move_done.
module face_turn_driver #(
  parameter int STEPS_PER_TURN     = 50,
  parameter int STEP_HIGH_CYCLES   = 50,
  parameter int STEP_PERIOD_CYCLES = 25000,
  parameter int DIR_SETUP_CYCLES   = 25,
  parameter int SETTLE_CYCLES      = 250000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] next_move,
  input  logic       move_start,
  output logic       move_done,
  output logic       busy,
  output logic       dir_pin,
  output logic       step_pin,
  output logic [5:0] en_pins
);

  localparam int LOW_CYCLES = STEP_PERIOD_CYCLES - STEP_HIGH_CYCLES;
  localparam int M0 = (DIR_SETUP_CYCLES > STEP_HIGH_CYCLES)
                    ? DIR_SETUP_CYCLES : STEP_HIGH_CYCLES;
  localparam int M1 = (M0 > LOW_CYCLES) ? M0 : LOW_CYCLES;
  localparam int MAXC = (M1 > SETTLE_CYCLES) ? M1 : SETTLE_CYCLES;
  localparam int TW = (MAXC < 2) ? 1 : $clog2(MAXC + 1);
  localparam int SW = (STEPS_PER_TURN < 2) ? 1 : $clog2(STEPS_PER_TURN + 1);

  localparam logic [TW-1:0] SETUP_LAST  = TW'(DIR_SETUP_CYCLES - 1);
  localparam logic [TW-1:0] HIGH_LAST   = TW'(STEP_HIGH_CYCLES - 1);
  localparam logic [TW-1:0] LOW_LAST    = TW'(LOW_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] STEPS_L     = SW'(STEPS_PER_TURN);

  typedef enum logic [2:0] {
    IDLE, ENABLE, STEP_HIGH, STEP_LOW, SETTLE, DONE
  } state_t;

  state_t        state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [SW-1:0] steps, steps_d, steps_inc;
  logic          start_q;
  logic          start_edge, code_ok;
  logic          done_d, busy_d, dir_d, step_d;
  logic [5:0]    en_d;

  assign start_edge = move_start & ~start_q;
  assign code_ok    = (next_move[3:1] != 3'd0) && (next_move[3:1] != 3'd7);
  assign steps_inc  = steps + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      timer     <= '0;
      steps     <= '0;
      start_q   <= 1'b0;
      move_done <= 1'b0;
      busy      <= 1'b0;
      dir_pin   <= 1'b0;
      step_pin  <= 1'b0;
      en_pins   <= 6'b111111;
    end else begin
      state     <= state_d;
      timer     <= timer_d;
      steps     <= steps_d;
      start_q   <= move_start;
      move_done <= done_d;
      busy      <= busy_d;
      dir_pin   <= dir_d;
      step_pin  <= step_d;
      en_pins   <= en_d;
    end
  end

  always_comb begin
    state_d = state;
    timer_d = timer + 1'b1;
    steps_d = steps;
    done_d  = 1'b0;
    busy_d  = busy;
    dir_d   = dir_pin;
    step_d  = step_pin;
    en_d    = en_pins;
    unique case (state)
      IDLE: begin
        timer_d = '0;
        if (start_edge) begin
          busy_d = 1'b1;
          if (code_ok) begin
            state_d = ENABLE;
            steps_d = '0;
            dir_d   = ~next_move[0];
            en_d    = ~(6'b000001 << (next_move[3:1] - 3'd1));
          end else begin
            state_d = DONE;
          end
        end
      end
      ENABLE: begin
        if (timer == SETUP_LAST) begin
          state_d = STEP_HIGH;
          timer_d = '0;
          step_d  = 1'b1;
        end
      end
      STEP_HIGH: begin
        if (timer == HIGH_LAST) begin
          state_d = STEP_LOW;
          timer_d = '0;
          step_d  = 1'b0;
        end
      end
      STEP_LOW: begin
        if (timer == LOW_LAST) begin
          timer_d = '0;
          steps_d = steps_inc;
          if (steps_inc == STEPS_L) begin
            state_d = SETTLE;
          end else begin
            state_d = STEP_HIGH;
            step_d  = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (timer == SETTLE_LAST) begin
          state_d = DONE;
          timer_d = '0;
          en_d    = 6'b111111;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        // invalid codes arrive here with done low and pulse it one cycle later
        timer_d = '0;
        if (move_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_face_turn_driver.sv
// Scoreboarded bench for face_turn_driver with shortened timing
// parameters; each scenario pushes its expectation before driving.
module tb_face_turn_driver;

  localparam int STEPS = 4;
  localparam int HIGH = 2;
  localparam int PERIOD = 5;
  localparam int SETUP = 3;
  localparam int SETTLE = 6;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] next_move;
  logic       move_start;
  logic       move_done, busy, dir_pin, step_pin;
  logic [5:0] en_pins;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int n_en_low;
    int en_val;
    int dir;
    int multi;
    int n_steps;
    int first_rise;
    int last_rise;
    int n_high;
    int n_done;
    int done_at;
    int done_en;
    int busy0;
    int busy_after;
  } obs_t;

  obs_t exp_q[$];

  face_turn_driver #(
    .STEPS_PER_TURN(STEPS),
    .STEP_HIGH_CYCLES(HIGH),
    .STEP_PERIOD_CYCLES(PERIOD),
    .DIR_SETUP_CYCLES(SETUP),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .next_move(next_move),
    .move_start(move_start),
    .move_done(move_done),
    .busy(busy),
    .dir_pin(dir_pin),
    .step_pin(step_pin),
    .en_pins(en_pins)
  );

  always #5 clock = ~clock;

  function automatic obs_t make_exp(input bit ok, input int en, input int dir);
    obs_t e;
    e = '{default: 0};
    e.busy0 = 1;
    e.done_en = 6'h3F;
    e.n_done = 1;
    e.first_rise = -1;
    if (ok) begin
      e.n_en_low = SETUP + STEPS * PERIOD + SETTLE;
      e.en_val = en;
      e.dir = dir;
      e.n_steps = STEPS;
      e.first_rise = SETUP;
      e.last_rise = SETUP + (STEPS - 1) * PERIOD;
      e.n_high = STEPS * HIGH;
      e.done_at = e.n_en_low;
    end else begin
      e.done_at = 1;
    end
    return e;
  endfunction

  task automatic observe(input int ncyc, input int hold,
                         input int inj, input logic [3:0] inj_code,
                         output obs_t o);
    logic prev;
    prev = 1'b0;
    o = '{default: 0};
    o.first_rise = -1;
    o.done_at = -1;
    o.busy_after = -1;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clock);
      #1;
      if (c == 0) o.busy0 = int'(busy);
      if (en_pins != 6'h3F) begin
        o.n_en_low++;
        o.en_val = int'(en_pins);
        o.dir = int'(dir_pin);
      end
      if ($countones(~en_pins) > 1) o.multi++;
      if (step_pin && !prev) begin
        o.n_steps++;
        if (o.first_rise < 0) o.first_rise = c;
        o.last_rise = c;
      end
      if (step_pin) o.n_high++;
      if (o.done_at >= 0 && c == o.done_at + 1) o.busy_after = int'(busy);
      if (move_done) begin
        o.n_done++;
        o.done_at = c;
        o.done_en = int'(en_pins);
      end
      prev = step_pin;
      if (c == hold - 1) move_start = 1'b0;
      if (inj >= 0 && c == inj) begin
        next_move = inj_code;
        move_start = 1'b1;
      end
      if (inj >= 0 && c == inj + 2) move_start = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    next_move = 4'd0;
    move_start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({en_pins, step_pin, dir_pin, move_done, busy} !== 10'b1111110000) begin
      errors++;
      $display("FAIL reset_vals: got en=%b st=%b dir=%b done=%b busy=%b want en=111111 rest 0",
               en_pins, step_pin, dir_pin, move_done, busy);
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic run_and_check(input string name, input logic [3:0] code,
                               input int ncyc, input int hold, input int inj,
                               input obs_t e_in);
    obs_t o, e;
    @(negedge clock);
    exp_q.push_back(e_in);
    next_move = code;
    move_start = 1'b1;
    observe(ncyc, hold, inj, 4'd2, o);
    e = exp_q.pop_front();
    checks++;
    if (o.n_en_low !== e.n_en_low || o.en_val !== e.en_val || o.multi !== 0) begin
      errors++;
      $display("FAIL %s_enable: got low=%0d en=%b multi=%0d want low=%0d en=%b multi=0",
               name, o.n_en_low, o.en_val[5:0], o.multi, e.n_en_low, e.en_val[5:0]);
    end
    checks++;
    if (o.dir !== e.dir) begin
      errors++;
      $display("FAIL %s_dir: got %0d want %0d", name, o.dir, e.dir);
    end
    checks++;
    if (o.n_steps !== e.n_steps || o.n_high !== e.n_high) begin
      errors++;
      $display("FAIL %s_steps: got n=%0d high=%0d want n=%0d high=%0d",
               name, o.n_steps, o.n_high, e.n_steps, e.n_high);
    end
    checks++;
    if (o.first_rise !== e.first_rise || o.last_rise !== e.last_rise) begin
      errors++;
      $display("FAIL %s_rise: got first=%0d last=%0d want first=%0d last=%0d",
               name, o.first_rise, o.last_rise, e.first_rise, e.last_rise);
    end
    checks++;
    if (o.n_done !== e.n_done || o.done_at !== e.done_at || o.done_en !== e.done_en) begin
      errors++;
      $display("FAIL %s_done: got n=%0d at=%0d en=%b want n=%0d at=%0d en=111111",
               name, o.n_done, o.done_at, o.done_en[5:0], e.n_done, e.done_at);
    end
    checks++;
    if (o.busy0 !== e.busy0 || o.busy_after !== e.busy_after) begin
      errors++;
      $display("FAIL %s_busy: got first=%0d after=%0d want first=%0d after=%0d",
               name, o.busy0, o.busy_after, e.busy0, e.busy_after);
    end
    move_start = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_plain();
    run_and_check("plain_F", 4'd6, 40, 2, -1, make_exp(1, 6'b111011, 1));
  endtask

  task automatic test_inverse();
    run_and_check("inv_Di", 4'd13, 40, 2, -1, make_exp(1, 6'b011111, 0));
  endtask

  task automatic test_invalid();
    run_and_check("bad_15", 4'd15, 5, 1, -1, make_exp(0, 0, 0));
    run_and_check("bad_0", 4'd0, 5, 1, -1, make_exp(0, 0, 0));
  endtask

  task automatic test_start_while_busy();
    run_and_check("busy_start", 4'd6, 60, 2, 9, make_exp(1, 6'b111011, 1));
  endtask

  task automatic test_held_start();
    run_and_check("held", 4'd6, 70, 60, -1, make_exp(1, 6'b111011, 1));
  endtask

  task automatic test_reset_mid_move();
    int dones;
    dones = 0;
    @(negedge clock);
    next_move = 4'd6;
    move_start = 1'b1;
    for (int c = 0; c <= SETUP + PERIOD; c++) begin
      @(posedge clock);
      #1;
      if (move_done) dones++;
      if (c == 1) move_start = 1'b0;
    end
    checks++;
    if (step_pin !== 1'b1) begin
      errors++;
      $display("FAIL abort_pulse2: got step=%b want 1", step_pin);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({en_pins, step_pin, dir_pin, move_done, busy} !== 10'b1111110000) begin
      errors++;
      $display("FAIL abort_async: got en=%b st=%b dir=%b done=%b busy=%b want en=111111 rest 0",
               en_pins, step_pin, dir_pin, move_done, busy);
    end
    repeat (4) begin
      @(posedge clock);
      #1;
      if (move_done) dones++;
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
      if (move_done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses want 0", dones);
    end
    run_and_check("after_U", 4'd4, 40, 2, -1, make_exp(1, 6'b111101, 1));
  endtask

  initial begin
    test_reset();
    test_plain();
    test_inverse();
    test_invalid();
    test_start_while_busy();
    test_held_start();
    test_reset_mid_move();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
